// File: rtl/multi_channel_sensor_sequencer.sv
// Scans the enabled sensors in ascending order through one shared ADC, averaging
// 2^avg_log2 conversions per channel and returning one result per channel.
module multi_channel_sensor_sequencer #(
  parameter int NUM_CHANNELS  = 4,
  parameter int ADC_WIDTH     = 16,
  parameter int CONFIG_WIDTH  = 3,
  parameter int SETTLE_TICKS  = 64,
  parameter int MAX_AVG_LOG2  = 3,
  parameter int TIMEOUT_TICKS = 4096
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    start,
  input  logic                    abort,
  input  logic [NUM_CHANNELS-1:0] chan_mask,
  input  logic [(MAX_AVG_LOG2 > 0 ? $clog2(MAX_AVG_LOG2 + 1) : 1)-1:0] avg_log2,
  input  logic [CONFIG_WIDTH-1:0] cfg_in,
  output logic                    busy,
  output logic                    done,
  output logic [NUM_CHANNELS-1:0] sens_enable,
  output logic [NUM_CHANNELS-1:0] sens_read,
  output logic [CONFIG_WIDTH-1:0] sens_config,
  output logic                    adc_enable,
  output logic                    adc_read,
  input  logic                    adc_conversion_complete,
  input  logic [ADC_WIDTH-1:0]    adc_value,
  output logic                    result_valid,
  input  logic                    result_ready,
  output logic [(NUM_CHANNELS > 1 ? $clog2(NUM_CHANNELS) : 1)-1:0] result_channel,
  output logic [ADC_WIDTH-1:0]    result_value,
  output logic                    result_timeout
);

  localparam int CH_W    = (NUM_CHANNELS > 1) ? $clog2(NUM_CHANNELS) : 1;
  localparam int AVG_W   = (MAX_AVG_LOG2 > 0) ? $clog2(MAX_AVG_LOG2 + 1) : 1;
  localparam int ACC_W   = ADC_WIDTH + MAX_AVG_LOG2;
  localparam int SAMP_W  = MAX_AVG_LOG2 + 2;
  localparam int CNT_MAX = (SETTLE_TICKS > TIMEOUT_TICKS) ? SETTLE_TICKS : TIMEOUT_TICKS;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_SETTLE,
    S_REQ,
    S_WAIT_LOW,
    S_EMIT,
    S_DONE
  } state_t;

  state_t                  state_q, state_d;
  logic [NUM_CHANNELS-1:0] mask_q, mask_d;
  logic [AVG_W-1:0]        avg_q, avg_d;
  logic [CONFIG_WIDTH-1:0] cfg_q, cfg_d;
  logic [CH_W-1:0]         ch_q, ch_d;
  logic [CNT_W-1:0]        cnt_q, cnt_d;
  logic [SAMP_W-1:0]       left_q, left_d;
  logic [ACC_W-1:0]        acc_q, acc_d;
  logic [CH_W-1:0]         res_ch_q, res_ch_d;
  logic [ADC_WIDTH-1:0]    res_val_q, res_val_d;
  logic                    res_tmo_q, res_tmo_d;

  logic                    first_found, next_found;
  logic [CH_W-1:0]         first_ch, next_ch;
  logic [AVG_W-1:0]        avg_clamped;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      mask_q    <= '0;
      avg_q     <= '0;
      cfg_q     <= '0;
      ch_q      <= '0;
      cnt_q     <= '0;
      left_q    <= '0;
      acc_q     <= '0;
      res_ch_q  <= '0;
      res_val_q <= '0;
      res_tmo_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      mask_q    <= mask_d;
      avg_q     <= avg_d;
      cfg_q     <= cfg_d;
      ch_q      <= ch_d;
      cnt_q     <= cnt_d;
      left_q    <= left_d;
      acc_q     <= acc_d;
      res_ch_q  <= res_ch_d;
      res_val_q <= res_val_d;
      res_tmo_q <= res_tmo_d;
    end
  end

  // Lowest set bit of the incoming mask, and lowest captured bit above the current channel.
  always_comb begin
    first_found = 1'b0;
    first_ch    = '0;
    next_found  = 1'b0;
    next_ch     = '0;
    for (int unsigned i = 0; i < NUM_CHANNELS; i++) begin
      if (chan_mask[i] && !first_found) begin
        first_found = 1'b1;
        first_ch    = CH_W'(i);
      end
      if (mask_q[i] && (CH_W'(i) > ch_q) && !next_found) begin
        next_found = 1'b1;
        next_ch    = CH_W'(i);
      end
    end
    avg_clamped = (avg_log2 > AVG_W'(MAX_AVG_LOG2)) ? AVG_W'(MAX_AVG_LOG2) : avg_log2;
  end

  always_comb begin
    state_d   = state_q;
    mask_d    = mask_q;
    avg_d     = avg_q;
    cfg_d     = cfg_q;
    ch_d      = ch_q;
    cnt_d     = cnt_q;
    left_d    = left_q;
    acc_d     = acc_q;
    res_ch_d  = res_ch_q;
    res_val_d = res_val_q;
    res_tmo_d = res_tmo_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          mask_d = chan_mask;
          avg_d  = avg_clamped;
          cfg_d  = cfg_in;
          if (first_found) begin
            ch_d    = first_ch;
            cnt_d   = '0;
            state_d = S_SETTLE;
          end else begin
            state_d = S_DONE;
          end
        end
      end
      S_SETTLE: begin
        acc_d  = '0;
        left_d = SAMP_W'(1) << avg_q;
        if (cnt_q == CNT_W'(SETTLE_TICKS - 1)) begin
          cnt_d   = '0;
          state_d = S_REQ;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      S_REQ: begin
        // A completion on the final allowed cycle still counts as a good sample.
        if (adc_conversion_complete) begin
          acc_d   = acc_q + ACC_W'(adc_value);
          left_d  = left_q - SAMP_W'(1);
          state_d = S_WAIT_LOW;
        end else if (cnt_q == CNT_W'(TIMEOUT_TICKS - 1)) begin
          res_ch_d  = ch_q;
          res_val_d = '0;
          res_tmo_d = 1'b1;
          state_d   = S_EMIT;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      S_WAIT_LOW: begin
        if (!adc_conversion_complete) begin
          if (left_q != '0) begin
            cnt_d   = '0;
            state_d = S_REQ;
          end else begin
            res_ch_d  = ch_q;
            res_val_d = ADC_WIDTH'(acc_q >> avg_q);
            res_tmo_d = 1'b0;
            state_d   = S_EMIT;
          end
        end
      end
      S_EMIT: begin
        if (result_ready) begin
          if (next_found) begin
            ch_d    = next_ch;
            cnt_d   = '0;
            state_d = S_SETTLE;
          end else begin
            state_d = S_DONE;
          end
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
    if (abort) begin
      state_d = S_IDLE;
    end
  end

  always_comb begin
    busy         = 1'b0;
    done         = 1'b0;
    sens_enable  = '0;
    sens_read    = '0;
    sens_config  = '0;
    adc_enable   = 1'b0;
    adc_read     = 1'b0;
    result_valid = 1'b0;
    case (state_q)
      S_SETTLE, S_WAIT_LOW: begin
        busy              = 1'b1;
        adc_enable        = 1'b1;
        sens_config       = cfg_q;
        sens_enable[ch_q] = 1'b1;
      end
      S_REQ: begin
        busy              = 1'b1;
        adc_enable        = 1'b1;
        sens_config       = cfg_q;
        sens_enable[ch_q] = 1'b1;
        sens_read[ch_q]   = 1'b1;
        adc_read          = 1'b1;
      end
      S_EMIT: begin
        busy         = 1'b1;
        adc_enable   = 1'b1;
        sens_config  = cfg_q;
        result_valid = 1'b1;
      end
      S_DONE:  done = 1'b1;
      default: ;
    endcase
  end

  assign result_channel = res_ch_q;
  assign result_value   = res_val_q;
  assign result_timeout = res_tmo_q;

endmodule

// File: tb/tb_multi_channel_sensor_sequencer.sv
// Randomised bench for the sensor sequencer: a transaction-level model predicts each
// scan's result stream from the mask, sample count and the ADC samples served.
module tb_multi_channel_sensor_sequencer;

  localparam int N      = 4;
  localparam int AW     = 16;
  localparam int CW     = 3;
  localparam int SETTLE = 64;
  localparam int TMO    = 4096;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          start = 1'b0;
  logic          abort = 1'b0;
  logic [N-1:0]  chan_mask = '0;
  logic [1:0]    avg_log2 = '0;
  logic [CW-1:0] cfg_in = '0;
  logic          adc_conversion_complete = 1'b0;
  logic [AW-1:0] adc_value = '0;
  logic          result_ready = 1'b0;
  logic          busy, done, adc_enable, adc_read, result_valid, result_timeout;
  logic [N-1:0]  sens_enable, sens_read;
  logic [CW-1:0] sens_config;
  logic [1:0]    result_channel;
  logic [AW-1:0] result_value;

  multi_channel_sensor_sequencer #(
    .NUM_CHANNELS(N), .ADC_WIDTH(AW), .CONFIG_WIDTH(CW),
    .SETTLE_TICKS(SETTLE), .MAX_AVG_LOG2(3), .TIMEOUT_TICKS(TMO)
  ) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .abort(abort), .chan_mask(chan_mask),
    .avg_log2(avg_log2), .cfg_in(cfg_in), .busy(busy), .done(done),
    .sens_enable(sens_enable), .sens_read(sens_read), .sens_config(sens_config),
    .adc_enable(adc_enable), .adc_read(adc_read),
    .adc_conversion_complete(adc_conversion_complete), .adc_value(adc_value),
    .result_valid(result_valid), .result_ready(result_ready),
    .result_channel(result_channel), .result_value(result_value),
    .result_timeout(result_timeout)
  );

  always #5 clk = ~clk;

  typedef struct { bit ign; bit chk; logic [AW-1:0] val; } plan_t;
  typedef struct { int ch; logic [AW-1:0] val; bit tmo; } res_t;

  plan_t         plans[$];
  res_t          exp_q[$];
  res_t          log_q[$];
  logic [AW-1:0] dir_vals[$];
  int            tests = 0, fails = 0;
  int            exp_reqs = 0, rises = 0, done_cnt = 0, scan_done0 = 0;
  int unsigned   cyc = 0, done_cyc = 0, t_start = 0;
  bit            first_pending = 0;
  logic [N-1:0]  mask_cap = '0;
  logic [CW-1:0] cfg_cap = '0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, want 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Model: channels in ascending order, mean of served samples, zero on timeout.
  task automatic build_scan(input logic [N-1:0] m, input int avg, input logic [N-1:0] tmo_m);
    int unsigned sum;
    logic [AW-1:0] v;
    plans.delete();
    exp_q.delete();
    exp_reqs = 0;
    for (int ch = 0; ch < N; ch++) begin
      if (m[ch]) begin
        if (tmo_m[ch]) begin
          plans.push_back('{1'b1, 1'b1, '0});
          exp_q.push_back('{ch, '0, 1'b1});
          exp_reqs++;
        end else begin
          sum = 0;
          for (int k = 0; k < (1 << avg); k++) begin
            v = (dir_vals.size() > 0) ? dir_vals.pop_front() : AW'($urandom);
            sum += v;
            plans.push_back('{1'b0, 1'b0, v});
            exp_reqs++;
          end
          exp_q.push_back('{ch, AW'(sum >> avg), 1'b0});
        end
      end
    end
  endtask

  task automatic start_scan(input logic [N-1:0] m, input int avg, input logic [CW-1:0] cfg);
    mask_cap      = m;
    cfg_cap       = cfg;
    chan_mask     = m;
    avg_log2      = 2'(avg);
    cfg_in        = cfg;
    log_q.delete();
    rises         = 0;
    first_pending = (m != '0);
    scan_done0    = done_cnt;
    t_start       = cyc;
    start         = 1'b1;
    tick();
    start         = 1'b0;
    chan_mask     = N'($urandom);
    cfg_in        = CW'($urandom);
    avg_log2      = 2'($urandom);
  endtask

  task automatic finish_scan(input int mode, input bit extra);
    int n = 0;
    while (done_cnt == scan_done0 && n < 20000) begin
      result_ready = (mode == 1) ? 1'b1 : ($urandom_range(0, 2) != 0);
      if (extra && busy && $urandom_range(0, 9) == 0) begin
        start     = 1'b1;
        chan_mask = N'($urandom);
      end else begin
        start = 1'b0;
      end
      tick();
      n++;
    end
    start        = 1'b0;
    result_ready = 1'b0;
    check("scan_done_pulses", done_cnt - scan_done0, 1);
    check("results_outstanding", exp_q.size(), 0);
    check("adc_read_requests", rises, exp_reqs);
  endtask

  // ADC responder: serves planned samples, or withholds completion for a planned timeout.
  initial begin : responder
    plan_t p;
    int n;
    forever begin
      tick();
      if (adc_read === 1'b1 && plans.size() > 0) begin
        p = plans.pop_front();
        if (p.ign) begin
          n = 1;
          while (n < TMO + 100) begin
            tick();
            if (adc_read !== 1'b1) break;
            n++;
          end
          if (p.chk) check("timeout_read_cycles", n, TMO);
        end else begin
          repeat ($urandom_range(0, 3)) tick();
          adc_value = p.val;
          adc_conversion_complete = 1'b1;
          n = 0;
          while (adc_read === 1'b1 && n < 200) begin
            tick();
            n++;
          end
          check("adc_read_release", n < 200, 1);
          adc_conversion_complete = 1'b0;
          adc_value = AW'($urandom);
        end
      end
    end
  end

  logic         prev_rd = 0, prev_valid = 0, prev_ready = 0, prev_abort = 0;
  logic [18:0]  prev_payload = '0;

  always @(negedge clk) begin
    res_t r, e;
    bit ok;
    if (rst_n) begin
      ok = ((sens_enable & ~mask_cap) == '0) && ($countones(sens_enable) <= 1) &&
           (sens_read == (adc_read ? sens_enable : '0)) && (!adc_read || sens_enable != '0) &&
           (busy == adc_enable) && (sens_config == (busy ? cfg_cap : '0)) &&
           (busy || (sens_enable == '0 && adc_read == 1'b0));
      tests++;
      if (!ok) begin
        fails++;
        $display("FAIL outputs_consistent: en=%b rd=%b adc_en=%b adc_rd=%b busy=%b cfg=%0h, want en within %b, cfg %0h (cycle %0d)",
                 sens_enable, sens_read, adc_enable, adc_read, busy, sens_config, mask_cap, cfg_cap, cyc);
      end
      if (adc_read && !prev_rd) begin
        rises++;
        if (first_pending) begin
          first_pending = 0;
          check("first_adc_read_cycle", cyc - t_start, SETTLE + 1);
        end
      end
      if (done) begin
        done_cnt++;
        done_cyc = cyc;
        check("done_while_idle", busy, 0);
      end
      if (result_valid && result_ready) begin
        r = '{int'(result_channel), result_value, result_timeout};
        log_q.push_back(r);
        check("result_expected", exp_q.size() != 0, 1);
        if (exp_q.size() != 0) begin
          e = exp_q.pop_front();
          check("result_channel", r.ch, e.ch);
          check("result_value", r.val, e.val);
          check("result_timeout", r.tmo, e.tmo);
        end
      end
      if (prev_valid && !prev_ready && !prev_abort) begin
        check("result_valid_held", result_valid, 1);
        check("result_payload_stable", {result_channel, result_value, result_timeout}, prev_payload);
      end
    end
    prev_rd      = adc_read;
    prev_valid   = result_valid;
    prev_ready   = result_ready;
    prev_abort   = abort;
    prev_payload = {result_channel, result_value, result_timeout};
  end

  initial begin : main
    int n, d0;
    bit ok;
    logic [N-1:0] m;
    int avg;

    repeat (3) tick();
    check("reset_outputs", {busy, done, sens_enable, sens_read, sens_config, adc_enable, adc_read,
                            result_valid, result_channel, result_value, result_timeout}, 0);
    rst_n = 1'b1;
    tick();
    check("idle_outputs", {busy, done, sens_enable, adc_enable, adc_read, result_valid}, 0);

    // Two sparse channels, single sample each, consumer always ready.
    dir_vals = '{16'h1234, 16'h00FF};
    build_scan(4'b0101, 0, 4'b0000);
    start_scan(4'b0101, 0, 3'd5);
    finish_scan(1, 0);
    check("t1_count", log_q.size(), 2);
    if (log_q.size() == 2) begin
      check("t1_r0", {log_q[0].ch[1:0], log_q[0].val, log_q[0].tmo}, {2'd0, 16'h1234, 1'b0});
      check("t1_r1", {log_q[1].ch[1:0], log_q[1].val, log_q[1].tmo}, {2'd2, 16'h00FF, 1'b0});
    end

    // Four-sample average with truncation: (10+11+12+14)>>2 = 11.
    dir_vals = '{16'd10, 16'd11, 16'd12, 16'd14};
    build_scan(4'b0001, 2, 4'b0000);
    start_scan(4'b0001, 2, 3'd2);
    finish_scan(0, 0);
    check("t2_rises", rises, 4);
    check("t2_value", (log_q.size() == 1) ? log_q[0].val : 16'hDEAD, 16'd11);

    // Channel 0 never completes; channel 1 proceeds normally.
    build_scan(4'b0011, 1, 4'b0001);
    start_scan(4'b0011, 1, 3'd7);
    finish_scan(1, 0);
    check("t3_count", log_q.size(), 2);
    if (log_q.size() == 2) begin
      check("t3_r0", {log_q[0].ch[1:0], log_q[0].val, log_q[0].tmo}, {2'd0, 16'h0000, 1'b1});
      check("t3_r1_tmo", log_q[1].tmo, 0);
    end

    // Back-pressure: result held for 20 cycles, next channel must not start.
    build_scan(4'b0011, 0, 4'b0000);
    start_scan(4'b0011, 0, 3'd1);
    result_ready = 1'b0;
    n = 0;
    while (result_valid !== 1'b1 && n < 2000) begin
      tick();
      n++;
    end
    check("t4_valid_seen", result_valid, 1);
    ok = 1;
    repeat (20) begin
      tick();
      ok = ok && result_valid && !sens_enable[1];
    end
    check("t4_stall_held", ok, 1);
    result_ready = 1'b1;
    tick();
    check("t4_ch1_settle", {result_valid, sens_enable}, {1'b0, 4'b0010});
    finish_scan(1, 0);

    // Abort while channel 1 is requesting; no done pulse, everything quiet.
    build_scan(4'b0011, 0, 4'b0010);
    plans[plans.size() - 1].chk = 0;
    void'(exp_q.pop_back());
    start_scan(4'b0011, 0, 3'd3);
    result_ready = 1'b1;
    n = 0;
    while (sens_read[1] !== 1'b1 && n < 2000) begin
      tick();
      n++;
    end
    check("t5_ch1_req", sens_read[1], 1);
    repeat (3) tick();
    d0 = done_cnt;
    abort = 1'b1;
    tick();
    abort = 1'b0;
    check("t5_abort_quiet", {busy, done, adc_read, adc_enable, sens_enable, sens_read, result_valid}, 0);
    repeat (10) tick();
    check("t5_no_done", done_cnt - d0, 0);
    check("t5_ch0_delivered", exp_q.size(), 0);
    plans.delete();
    result_ready = 1'b0;

    // Empty mask: done the cycle after start, no results.
    build_scan(4'b0000, 0, 4'b0000);
    start_scan(4'b0000, 0, 3'd4);
    finish_scan(1, 0);
    check("t6_done_cycle", done_cyc - t_start, 1);
    check("t6_no_results", log_q.size(), 0);

    // Random scans with stray start pulses while busy.
    for (int i = 0; i < 10; i++) begin
      m   = N'($urandom);
      avg = $urandom_range(0, 3);
      build_scan(m, avg, 4'b0000);
      start_scan(m, avg, CW'($urandom));
      finish_scan(0, 1);
      check("rand_result_count", log_q.size(), $countones(m));
      repeat ($urandom_range(1, 4)) tick();
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin : watchdog
    #3000000;
    $display("FAIL watchdog: bench did not complete, %0d tests run", tests);
    $fatal(1, "bench time limit reached");
  end

endmodule

// File: doc/multi_channel_sensor_sequencer.md
Name: multi_channel_sensor_sequencer

Overview:
- Parametrised successor to the single-sensor/ADC control path. Drives NUM_CHANNELS radiation sensors through one shared ADC.
- Per scan: walks the enabled channels in ascending index order and gives each a settle period. Takes 2^avg_log2 ADC samples per channel, averages them, and returns one result per channel over a valid/ready interface.
- Sits between the app-level adapter (command decode / response build) and the analogue sensor/ADC pads. ADC conversion-complete arrives already synchronised.

Parameters:
- NUM_CHANNELS, 4, number of sensors (1..8).
- ADC_WIDTH, 16, ADC sample width.
- CONFIG_WIDTH, 3, sensor config bus width.
- SETTLE_TICKS, 64, clk cycles from enable to first adc_read (>=1).
- MAX_AVG_LOG2, 3, maximum log2 of the sample count.
- TIMEOUT_TICKS, 4096, clk cycles allowed per conversion before timeout.

Ports:
- clk  in  1  13.56MHz clock.
- rst_n  in  1  reset.
- start  in  1  single-cycle scan request.
- abort  in  1  cancel scan.
- chan_mask  in  NUM_CHANNELS  channels to scan.
- avg_log2  in  $clog2(MAX_AVG_LOG2+1)  samples per channel = 2^avg_log2.
- cfg_in  in  CONFIG_WIDTH  sensor configuration.
- busy  out  1  scan in progress.
- done  out  1  one-cycle pulse at scan end.
- sens_enable  out  NUM_CHANNELS  per-sensor enable.
- sens_read  out  NUM_CHANNELS  per-sensor read strobe.
- sens_config  out  CONFIG_WIDTH  applied config.
- adc_enable  out  1  ADC power enable.
- adc_read  out  1  conversion request.
- adc_conversion_complete  in  1  synchronised completion.
- adc_value  in  ADC_WIDTH  sample, stable while complete is high.
- result_valid  out  1  result available.
- result_ready  in  1  consumer accepts.
- result_channel  out  $clog2(NUM_CHANNELS) (min 1)  channel index.
- result_value  out  ADC_WIDTH  averaged sample.
- result_timeout  out  1  channel timed out.

Behaviour:
- One clock, clk. Reset rst_n is asynchronous, active-low.
- Reset values: every output is 0; FSM is in IDLE.
- FSM states: IDLE, SETTLE, REQ, WAIT_LOW, EMIT, DONE.
- IDLE:
  - start=1 captures chan_mask, avg_log2 (clamped to MAX_AVG_LOG2) and cfg_in; busy=1 next cycle.
  - If the captured mask is 0: go to DONE (done pulses on the cycle after start), no results.
  - Otherwise select the lowest set bit and go to SETTLE.
- start while busy is ignored. Inputs are not re-sampled mid-scan.
- SETTLE:
  - sens_enable[ch]=1, adc_enable=1 and sens_config=captured cfg from the cycle after start (T+1).
  - Counter runs SETTLE_TICKS cycles; adc_read first asserts at T+1+SETTLE_TICKS.
  - The accumulator is cleared.
- REQ:
  - adc_read=1 and sens_read[ch]=1 (all other sens_read bits 0) until adc_conversion_complete=1.
  - On that cycle: add adc_value into an accumulator of width ADC_WIDTH+MAX_AVG_LOG2 (no overflow possible), then drop adc_read/sens_read.
  - Timeout counter resets on entry to REQ. If it reaches TIMEOUT_TICKS with no completion: drop adc_read, set the timeout flag, skip the remaining samples and go to EMIT.
- WAIT_LOW (four-phase handshake):
  - Wait for adc_conversion_complete=0.
  - Then go to REQ if samples remain, else EMIT.
- EMIT:
  - result_value = accumulator >> avg_log2 (truncating). It is 0 if timed out; result_timeout = flag; result_channel = ch.
  - result_valid is held, with payload stable, until result_ready=1. Transfer happens on valid&&ready.
  - sens_enable[ch] drops on entry to EMIT; adc_enable stays high between channels.
  - After the transfer: next set mask bit goes to SETTLE, else DONE.
- DONE: done=1 for one cycle, busy=0, adc_enable=0, then IDLE.
- Higher-index channels are never skipped; a channel with its mask bit clear is never enabled.
- Channel index does not wrap: the scan ends after the highest set bit.
- abort (any state):
  - Next cycle the FSM is in IDLE and all outputs except result_* are 0.
  - Any unaccepted result is dropped (result_valid=0); done is not pulsed.
  - abort takes priority over a simultaneous start or a transfer.
- result_ready with result_valid=0 has no effect.
- avg_log2=0 gives exactly one sample, and result_value equals adc_value.

Test Plan:
- NUM_CHANNELS=4, mask=4'b0101, avg_log2=0; ADC returns 16'h1234 then 16'h00FF; ready tied 1 -> results (ch0, 16'h1234, timeout 0) then (ch2, 16'h00FF, timeout 0); done pulses once; sens_enable[1] and [3] never assert.
- mask=4'b0001, avg_log2=2; samples 10, 11, 12, 14 -> result_value=11 (47>>2); exactly 4 adc_read rising edges; first adc_read at start+1+64 cycles.
- mask=4'b0011; ch0 complete never asserts -> after 4096 cycles adc_read drops; (ch0, 0, timeout 1) is emitted, then ch1 proceeds normally.
- result_ready held 0 for 20 cycles -> result_valid stays 1, payload stable, no ch1 sens_enable; ready=1 -> transfer, ch1 settle begins.
- abort during ch1 REQ -> next cycle busy=0, adc_read=0, sens_enable=0, adc_enable=0, no done; new start with mask=0 -> done pulses at start+1 with no results.
- start repeated while busy -> ignored; scan result sequence is unchanged.
